mhd_err_inj: RTL and testbench

Sequential Hamming-distance error injector: accepts a WIDTH-bit golden word and a target distance k, then flips exactly k distinct bit positions chosen by an internal LFSR. It produces a word pair at a known Hamming distance. It is the stimulus-side counterpart of the combinational Hamming-distance miter and sits in the approximate-circuit evaluation harness, in front of that miter. Output is a mutated word plus the flip mask, delivered over valid/ready.

---
 rtl/mhd_err_inj.sv | 146 ++++++++++++++
 tb/tb_mhd_err_inj.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/mhd_err_inj.sv
// mhd_err_inj: sequential Hamming-distance error injector.
// Takes a golden word and a distance k, then flips exactly min(k, WIDTH)
// distinct bits chosen by a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1),
// at one candidate position per cycle. It returns the mutated word, the flip
// mask and the effective distance.
// Optional feature macro: MHD_INJ_CHECK_EN adds a registered popcount of the
// mask and a sticky self-consistency flag on the extra output 'err'.
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. A valid that has been raised stays high with stable payload
// until that transfer. in_valid is ignored whenever in_ready is low.
module mhd_err_inj #(
   parameter int          WIDTH = 129,
   parameter int          KW    = 8,
   parameter int          PW    = 8,
   parameter logic [15:0] SEED  = 16'hACE1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic [KW-1:0]    in_k,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [WIDTH-1:0] out_mask,
   output logic [KW-1:0]    out_dist,
   output logic             busy
`ifdef MHD_INJ_CHECK_EN
   ,
   output logic             err
`endif
);

   // An all-zero LFSR would lock up, so a zero seed becomes 1.
   localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
   localparam logic [KW-1:0] WIDTH_K = KW'(WIDTH);

   typedef enum logic [1:0] {IDLE, INJECT, DONE} state_t;

   state_t           state_q, state_d;
   logic [15:0]      lfsr_q, lfsr_d, lfsr_adv;
   logic [WIDTH-1:0] mask_q, mask_d;
   logic [WIDTH-1:0] data_q, data_d;
   logic [WIDTH-1:0] dout_q;
   logic [KW-1:0]    k_q, k_d;
   logic [KW-1:0]    cnt_q, cnt_d;
   logic [PW-1:0]    pos;
   logic             pos_ok;

   // The candidate comes from the post-advance LFSR value. It is usable only
   // when it is in range and has not been flipped already.
   assign lfsr_adv = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   assign pos      = lfsr_adv[PW-1:0];
   assign pos_ok   = (32'(pos) < 32'(WIDTH)) && !mask_q[pos];

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign busy      = (state_q != IDLE);
   assign out_data  = dout_q;
   assign out_mask  = mask_q;
   assign out_dist  = k_q;

   // Next-state and datapath: capture in IDLE, one candidate per INJECT cycle,
   // and hold in DONE until the consumer takes the result.
   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      mask_d  = mask_q;
      data_d  = data_q;
      k_d     = k_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               data_d  = in_data;
               mask_d  = '0;
               cnt_d   = '0;
               k_d     = (32'(in_k) > 32'(WIDTH)) ? WIDTH_K : in_k;
               state_d = (k_d == '0) ? DONE : INJECT;
            end
         end
         INJECT: begin
            lfsr_d = lfsr_adv;
            if (pos_ok) begin
               mask_d[pos] = 1'b1;
               cnt_d       = cnt_q + KW'(1);
               if (cnt_d == k_q) state_d = DONE;
            end
         end
         DONE: begin
            if (out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers. out_data is registered from the next mask.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_EFF;
         mask_q  <= '0;
         data_q  <= '0;
         dout_q  <= '0;
         k_q     <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         mask_q  <= mask_d;
         data_q  <= data_d;
         dout_q  <= data_d ^ mask_d;
         k_q     <= k_d;
         cnt_q   <= cnt_d;
      end
   end

`ifdef MHD_INJ_CHECK_EN
   function automatic logic [KW-1:0] popcnt(input logic [WIDTH-1:0] v);
      logic [KW-1:0] c;
      c = '0;
      for (int i = 0; i < WIDTH; i++) c = c + KW'(v[i]);
      return c;
   endfunction

   logic [KW-1:0] pop_q;
   logic          err_q;

   // The popcount tracks mask_q in the same cycle because it is taken from
   // mask_d. The error flag is sticky until rst.
   always_ff @(posedge clk) begin
      if (rst) begin
         pop_q <= '0;
         err_q <= 1'b0;
      end else begin
         pop_q <= popcnt(mask_d);
         if (state_q == DONE && (pop_q != k_q || (data_q ^ dout_q) != mask_q))
            err_q <= 1'b1;
      end
   end

   assign err = err_q;
`endif

endmodule

// File: tb/tb_mhd_err_inj.sv
// tb_mhd_err_inj: scoreboard bench for mhd_err_inj.
// The driver pushes the expected {out_data, out_mask, out_dist} for each word.
// A negedge monitor compares every cycle out_valid is high and pops the entry
// on the handshake. Masks come from a bench model of the specified LFSR.
module tb_mhd_err_inj;
   localparam int W  = 129;
   localparam int KW = 8;
   localparam logic [15:0] SEED = 16'hACE1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0, in_valid2 = 1'b0;
   logic          in_ready, in_ready2;
   logic [W-1:0]  in_data = '0;
   logic [KW-1:0] in_k = '0;
   logic          out_valid, out_valid2;
   logic          out_ready = 1'b0;
   logic          out_ready2 = 1'b1;
   logic [W-1:0]  out_data, out_mask, out_data2, out_mask2;
   logic [KW-1:0] out_dist, out_dist2;
   logic          busy, busy2;
`ifdef MHD_INJ_CHECK_EN
   logic          err, err2;
`endif

   logic [2*W+KW-1:0] exp_q[$];
   logic [15:0]       lfsr_m;
   int                n_cmp = 0;
   int                n_bad = 0;

   // clock/reset block
   always #5 clk = ~clk;

   mhd_err_inj #(.WIDTH(W), .KW(KW), .PW(8), .SEED(SEED)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_k(in_k), .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_mask(out_mask), .out_dist(out_dist), .busy(busy)
`ifdef MHD_INJ_CHECK_EN
      , .err(err)
`endif
   );

   // Second instance with a zero seed, which the design must replace by 1.
   mhd_err_inj #(.WIDTH(W), .KW(KW), .PW(8), .SEED(16'h0000)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_data(in_data), .in_k(in_k), .out_valid(out_valid2), .out_ready(out_ready2),
      .out_data(out_data2), .out_mask(out_mask2), .out_dist(out_dist2), .busy(busy2)
`ifdef MHD_INJ_CHECK_EN
      , .err(err2)
`endif
   );

   function automatic logic [W-1:0] rnd_word();
      return {$urandom(), $urandom(), $urandom(), $urandom(), 1'($urandom_range(1, 0))};
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   // Reference model: walk the LFSR until keff distinct in-range positions are set.
   task automatic model(input logic [15:0] l_in, input int keff, output logic [15:0] l_out,
                        output logic [W-1:0] m, output int tries);
      logic [15:0] l;
      int cnt;
      l = l_in; m = '0; cnt = 0; tries = 0;
      while (cnt < keff) begin
         l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
         tries++;
         if (int'(l[7:0]) < W && m[l[7:0]] == 1'b0) begin
            m[l[7:0]] = 1'b1;
            cnt++;
         end
      end
      l_out = l;
   endtask

   // scoreboard monitor
   always @(negedge clk) begin
      if (!rst && out_valid) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL out_word: got unexpected output mask=%h, want none", out_mask);
         end else begin
            if ({out_data, out_mask, out_dist} !== exp_q[0]) begin
               n_bad++;
               $display("FAIL out_word: got data=%h mask=%h dist=%0d, want data=%h mask=%h dist=%0d",
                        out_data, out_mask, out_dist, exp_q[0][2*W+KW-1:W+KW],
                        exp_q[0][W+KW-1:KW], exp_q[0][KW-1:0]);
            end
            if (out_ready) void'(exp_q.pop_front());
         end
      end
   end

   task automatic do_reset();
      rst = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b0;
      lfsr_m = SEED;
   endtask

   // driver: called at posedge+1 with the DUT idle
   task automatic send(input logic [W-1:0] d, input logic [7:0] k, input int hold);
      int keff, tries, cyc;
      logic [W-1:0] m;
      keff = (int'(k) > W) ? W : int'(k);
      model(lfsr_m, keff, lfsr_m, m, tries);
      exp_q.push_back({d ^ m, m, KW'(keff)});
      in_valid = 1'b1; in_data = d; in_k = k;
      @(posedge clk); #1;
      // junk offered while busy must be ignored
      in_data = rnd_word(); in_k = 8'($urandom_range(255, 0));
      chk("ready_busy_after_accept", W'({in_ready, busy}), W'(2'b01));
      cyc = 1;
      while (!out_valid && cyc < 20000) begin @(posedge clk); #1; cyc++; end
      chk("latency", W'(cyc), W'(tries + 1));
      repeat (hold) begin @(posedge clk); #1; end
      if (keff == 48) begin
         chk("popcount48", W'($countones(d ^ out_data)), W'(48));
         chk("miter_mhd47_f", W'($countones(d ^ out_data) > 47), W'(1));
      end
      in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      chk("ready_after_handshake", W'({in_ready, out_valid, busy}), W'(3'b100));
   endtask

   initial begin
      logic [W-1:0] ones, m1, m2;
      logic [15:0]  ltmp;
      int           t, cyc;
      ones = '1;
      do_reset();
      rst = 1'b1; @(posedge clk); #1;
      chk("reset_flags", W'({in_ready, out_valid, busy}), W'(3'b100));
      chk("reset_data", out_data, '0);
      chk("reset_mask", out_mask, '0);
      chk("reset_dist", W'(out_dist), '0);
      rst = 1'b0;

      send(ones, 8'd0, 0);
      send('0, 8'd1, 0);
      send(rnd_word(), 8'd48, 10);
      send('0, 8'd200, 0);
      send(rnd_word(), 8'd8, 0);
      send({W{1'b1}} >> 5, 8'd129, 2);

      // Reproducibility: same sequence from reset must give the same masks.
      do_reset();
      send('0, 8'd5, 0);
      send(ones, 8'd8, 1);

      // Abort three cycles into INJECT.
      in_valid = 1'b1; in_data = rnd_word(); in_k = 8'd64;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      lfsr_m = SEED;
      chk("abort_flags", W'({in_ready, out_valid, busy}), W'(3'b100));
      chk("abort_mask", out_mask, '0);
      send(rnd_word(), 8'd2, 0);

      // Seed check on the zero-seed instance.
      model(16'h0001, 8, ltmp, m2, t);
      model(SEED, 8, ltmp, m1, t);
      in_valid2 = 1'b1; in_data = '0; in_k = 8'd8;
      @(posedge clk); #1;
      in_valid2 = 1'b0;
      cyc = 0;
      do begin @(negedge clk); cyc++; end while (!out_valid2 && cyc < 20000);
      chk("seed1_valid", W'(out_valid2), W'(1));
      chk("seed1_mask", out_mask2, m2);
      chk("seed_masks_differ", W'(out_mask2 != m1), W'(1));

      repeat (3) @(posedge clk);
      chk("queue_empty", W'(exp_q.size()), '0);
`ifdef MHD_INJ_CHECK_EN
      chk("err_flag", W'({err, err2}), '0);
`endif
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
